alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two 32-bit operands.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU) produce a registered result one cycle after acceptance.
- Shifts (SLL, SRL, SRA) run iteratively, one bit per cycle.
- Valid/ready handshakes on both the input side and the result side let the core stall around multi-cycle shifts.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; shamt is operand B[SHAMT_WIDTH-1:0].

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands and control code valid.
- o_ready  output  1  unit can accept a new operation this cycle.
- i_ALUControlLines  input  4  ALU op code (shared ALU_* encoding).
- i_OpA  input  DATA_WIDTH  operand A.
- i_OpB  input  DATA_WIDTH  operand B; low SHAMT_WIDTH bits are the shamt for shifts.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_Result  output  DATA_WIDTH  result.
- o_Zero  output  1  o_Result == 0; used for branch resolution with SUB.
- o_IllegalOp  output  1  control code not in the ALU_* set; qualified by o_valid.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_valid=0, o_Result=0, o_Zero=1, o_IllegalOp=0, o_ready=1.
  - Internal shift register and counter cleared.
- Accept rule: transfer when i_valid && o_ready. Operands and control code are captured on that edge; later input changes are ignored.
- o_ready is high when:
  - state==IDLE, or
  - state==DONE && i_ready (back-to-back issue allowed).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE --accept non-shift--> DONE. Result computed combinationally from the inputs and registered, so o_valid rises 1 cycle after accept.
  - IDLE --accept shift, shamt!=0--> SHIFT. Load the shift register with A and the counter with shamt.
  - IDLE --accept shift, shamt==0--> DONE with result=A; latency 1.
  - SHIFT: each cycle shift by 1 and decrement the counter.
    - SLL fills with 0.
    - SRL fills with 0.
    - SRA fills with the captured A[DATA_WIDTH-1].
    - When the counter reaches 1, that cycle's shift completes and next state=DONE.
    - Total latency = shamt+1 cycles (shamt=31 gives 32 cycles).
  - DONE: o_valid=1; o_Result/o_Zero/o_IllegalOp are held stable until i_ready.
    - i_ready && !i_valid: go to IDLE; o_valid drops next cycle.
    - i_ready && i_valid: accept the new op; behaves as the IDLE transition from this cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow output.
  - SLT: signed compare, result {31'b0, A<B}.
  - SLTU: unsigned compare, same result form.
- Illegal code: result=0, o_Zero=1, o_IllegalOp=1, latency 1. Never X on outputs.
- i_valid while busy (SHIFT, or DONE without i_ready) is not accepted; the upstream stage holds it.
- Async reset mid-shift aborts immediately; the partial result is discarded.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter; every op, including shamt=31, has latency 1. The SHIFT state and counter are not instantiated. o_ready follows the same rule.
- Undefined: iterative shift as above (smaller area, variable latency).

Decomposition:
- Shared header (existing ALU control defines) provides the ALU_* 4-bit codes.
- Add to that header: FSM state encodings (ALU_ST_IDLE=2'd0, ALU_ST_SHIFT=2'd1, ALU_ST_DONE=2'd2) and an is-shift helper macro.
- One natural sub-module, alu_shift_iter: shift register, counter and done pulse. Replaced by the barrel shifter under ALU_FAST_SHIFT_EN.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF B=1 with i_ready=1 -> o_valid 1 cycle later, o_Result=0x80000000, o_Zero=0.
- SUB A=5 B=5 -> o_Result=0, o_Zero=1. SLT A=0xFFFFFFFF B=1 -> 1. SLTU with the same operands -> 0.
- SRA A=0x80000000 shamt=31 -> o_valid exactly 32 cycles after accept, o_Result=0xFFFFFFFF; o_ready=0 throughout.
- SLL A=0x1 shamt=0 -> latency 1, o_Result=0x1. SRL A=0xF0 shamt=4 -> latency 5, result 0x0F.
- Back-pressure: hold i_ready=0 for 3 cycles after XOR 0xFF^0x0F -> o_Result=0xF0 held stable. Then raise i_ready with the next op valid -> accepted the same cycle, no bubble.
- Illegal code 4'hF -> o_IllegalOp=1, o_Result=0. Assert i_rst_n=0 mid-SLL shamt=20 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes, FSM state encodings and op-class helpers for alu_exec_unit.
// Optional build macro ALU_FAST_SHIFT_EN is consumed by the top, not here.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;

    typedef enum logic [1:0] {
        ALU_ST_IDLE  = 2'd0,
        ALU_ST_SHIFT = 2'd1,
        ALU_ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic alu_is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    // Codes above ALU_SRA are unassigned and reported as illegal.
    function automatic logic alu_is_legal(input logic [3:0] code);
        return code <= ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bus of the execute-stage ALU, with upstream (master) and ALU (slave) views.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32
);
    // Handshake: an op transfers on a rising edge where i_valid && o_ready; a result
    // transfers where o_valid && i_ready. A source holds its payload until it transfers.
    logic                  i_valid;
    logic                  o_ready;
    logic [3:0]            i_ALUControlLines;
    logic [DATA_WIDTH-1:0] i_OpA;
    logic [DATA_WIDTH-1:0] i_OpB;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_Result;
    logic                  o_Zero;
    logic                  o_IllegalOp;

    modport master (
        output i_valid, i_ALUControlLines, i_OpA, i_OpB, i_ready,
        input  o_ready, o_valid, o_Result, o_Zero, o_IllegalOp
    );

    modport slave (
        input  i_valid, i_ALUControlLines, i_OpA, i_OpB, i_ready,
        output o_ready, o_valid, o_Result, o_Zero, o_IllegalOp
    );
endinterface

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative one-bit-per-cycle shifter: loads A and shamt, then shifts until the counter empties.
module alu_shift_iter
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [3:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  result_o
);
    logic [DATA_WIDTH-1:0]  sreg_q, sreg_d, shifted;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   left_q, left_d;
    logic                   fill_q, fill_d;

    // Right shifts insert fill_q, which is the captured sign bit for SRA and 0 for SRL.
    assign shifted  = left_q ? {sreg_q[DATA_WIDTH-2:0], 1'b0} : {fill_q, sreg_q[DATA_WIDTH-1:1]};
    assign busy_o   = (cnt_q != '0);
    assign done_o   = (cnt_q == SHAMT_WIDTH'(1));
    assign result_o = shifted;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        fill_d = fill_q;
        if (load_i) begin
            sreg_d = a_i;
            cnt_d  = shamt_i;
            left_d = (op_i == ALU_SLL);
            fill_d = (op_i == ALU_SRA) && a_i[DATA_WIDTH-1];
        end else if (busy_o) begin
            sreg_d = shifted;
            cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts instead of the iterative shifter.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_exec_unit_if.slave       bus,
    output alu_state_e           o_dbg_state
);
    alu_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d, alu_res, a, b;
    logic                   illegal_q, illegal_d;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   ready, accept, iter_start, shift_done;
    logic [DATA_WIDTH-1:0]  shift_res;

    assign a      = bus.i_OpA;
    assign b      = bus.i_OpB;
    assign shamt  = b[SHAMT_WIDTH-1:0];
    assign ready  = (state_q == ALU_ST_IDLE) || ((state_q == ALU_ST_DONE) && bus.i_ready);
    assign accept = bus.i_valid && ready;

    always_comb begin
        alu_res = '0;
        case (bus.i_ALUControlLines)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
`else
            // Only reached with shamt == 0; non-zero shifts go through the iterative shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
`endif
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign iter_start = 1'b0;
    assign shift_done = 1'b0;
    assign shift_res  = '0;
`else
    assign iter_start = accept && alu_is_shift(bus.i_ALUControlLines) && (shamt != '0);

    alu_shift_iter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift_iter (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .load_i   (iter_start),
        .op_i     (bus.i_ALUControlLines),
        .a_i      (a),
        .shamt_i  (shamt),
        .busy_o   (),
        .done_o   (shift_done),
        .result_o (shift_res)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            ALU_ST_IDLE, ALU_ST_DONE: begin
                if (accept) begin
                    if (iter_start) begin
                        state_d   = ALU_ST_SHIFT;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = ALU_ST_DONE;
                        result_d  = alu_res;
                        illegal_d = !alu_is_legal(bus.i_ALUControlLines);
                    end
                end else if ((state_q == ALU_ST_DONE) && bus.i_ready) begin
                    state_d = ALU_ST_IDLE;
                end
            end
            ALU_ST_SHIFT: begin
                if (shift_done) begin
                    state_d  = ALU_ST_DONE;
                    result_d = shift_res;
                end
            end
            default: state_d = ALU_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ALU_ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = (state_q == ALU_ST_DONE);
    assign bus.o_Result    = result_q;
    assign bus.o_Zero      = (result_q == '0);
    assign bus.o_IllegalOp = illegal_q;
    assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit plus back-pressure and mid-shift reset sequences.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    alu_state_e dbg_state;
    int         n_cmp = 0;
    int         n_err = 0;

    alu_exec_unit_if #(.DATA_WIDTH(32)) bus ();

    alu_exec_unit #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic zero,
                           input logic ill, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.zero = zero; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge with the DUT idle; leaves it idle again.
    task automatic run_vec(input vec_t v);
        int lat;
        int busy_ready;
        int exp_lat;
        exp_lat = v.lat;
`ifdef ALU_FAST_SHIFT_EN
        exp_lat = 1;
`endif
        bus.i_ALUControlLines = v.op;
        bus.i_OpA   = v.a;
        bus.i_OpB   = v.b;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_OpA   = $urandom;
        bus.i_OpB   = $urandom;
        bus.i_ALUControlLines = 4'($urandom_range(0, 15));
        lat = 1;
        busy_ready = 0;
        while (!bus.o_valid && lat < 40) begin
            if (bus.o_ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, ".latency"}, lat, exp_lat);
        check({v.name, ".result"}, bus.o_Result, v.res);
        check({v.name, ".zero"}, {31'b0, bus.o_Zero}, {31'b0, v.zero});
        check({v.name, ".illegal"}, {31'b0, bus.o_IllegalOp}, {31'b0, v.ill});
        check({v.name, ".ready_while_busy"}, busy_ready, 0);
        @(posedge clk); #1;
        check({v.name, ".valid_after_consume"}, {31'b0, bus.o_valid}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".valid"}, {31'b0, bus.o_valid}, 32'd0);
        check({tag, ".result"}, bus.o_Result, 32'd0);
        check({tag, ".zero"}, {31'b0, bus.o_Zero}, 32'd1);
        check({tag, ".illegal"}, {31'b0, bus.o_IllegalOp}, 32'd0);
        check({tag, ".ready"}, {31'b0, bus.o_ready}, 32'd1);
        check({tag, ".state"}, 32'(dbg_state), 32'(ALU_ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_ALUControlLines = 4'h0;
        bus.i_OpA = 32'h0;
        bus.i_OpB = 32'h0;

        add_vec("add_ovf",   ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1);
        add_vec("sub_eq",    ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("slt_neg",   ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
        add_vec("sltu_big",  ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1);
        add_vec("or",        ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1);
        add_vec("xor",       ALU_XOR,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 1);
        add_vec("sub_wrap",  ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
        add_vec("add_wrap0", ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("sra_31",    ALU_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32);
        add_vec("sll_0",     ALU_SLL,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1);
        add_vec("srl_4",     ALU_SRL,  32'h000000F0, 32'h00000004, 32'h0000000F, 1'b0, 1'b0, 5);
        add_vec("sll_hi_b",  ALU_SLL,  32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0, 1'b0, 4);
        add_vec("srl_31",    ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 32);
        add_vec("sra_pos",   ALU_SRA,  32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 5);
        add_vec("sra_1",     ALU_SRA,  32'h80000001, 32'h00000001, 32'hC0000000, 1'b0, 1'b0, 2);
        add_vec("illegal_f", 4'hF,     32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 1);
        add_vec("illegal_a", 4'hA,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1);

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: result must hold while i_ready is low, then issue back-to-back.
        bus.i_ready = 1'b0;
        bus.i_ALUControlLines = ALU_XOR;
        bus.i_OpA = 32'h000000FF;
        bus.i_OpB = 32'h0000000F;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_OpA = $urandom;
        bus.i_OpB = $urandom;
        for (int c = 0; c < 3; c++) begin
            check("bp.valid", {31'b0, bus.o_valid}, 32'd1);
            check("bp.result", bus.o_Result, 32'h000000F0);
            check("bp.ready_low", {31'b0, bus.o_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("bp.held_result", bus.o_Result, 32'h000000F0);
        bus.i_ALUControlLines = ALU_ADD;
        bus.i_OpA = 32'd2;
        bus.i_OpB = 32'd3;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        check("b2b.ready", {31'b0, bus.o_ready}, 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("b2b.valid", {31'b0, bus.o_valid}, 32'd1);
        check("b2b.result", bus.o_Result, 32'd5);
        @(posedge clk); #1;
        check("b2b.drained", {31'b0, bus.o_valid}, 32'd0);

        // Asynchronous reset in the middle of a long shift.
        bus.i_ALUControlLines = ALU_SLL;
        bus.i_OpA = 32'h00000001;
        bus.i_OpB = 32'd20;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
`ifndef ALU_FAST_SHIFT_EN
        check("midshift.ready", {31'b0, bus.o_ready}, 32'd0);
        check("midshift.state", 32'(dbg_state), 32'(ALU_ST_SHIFT));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[4]);
        run_vec(vecs[11]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
